input_filter_ctrl: RTL and testbench

Per-channel controller for the input synchronizer bank. It drives each synchronizer's reset-mode select (`wd_rst`) and runs a programmable glitch filter (debounce counter plus state machine) on each synchronized output. It produces stable filtered levels and single-cycle rise/fall event pulses, and optionally sticky interrupt status. It sits between the synchronizer instances and the digital core logic that consumes filtered inputs.

---
 rtl/input_filter_ctrl.sv | 151 +++++++++++++++
 tb/tb_input_filter_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_filter_ctrl.sv
// Per-channel synchronizer mode control and programmable glitch filter with rise/fall event pulses.
// Optional sticky interrupt status is enabled by defining FILTER_IRQ_EN.
module input_filter_ctrl #(
   parameter int               NUM_CH  = 4,
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] DEF_LEN = CNT_W'(3),
   localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] sync_data_i,
   output logic [NUM_CH-1:0] wd_rst_o,
   input  logic              cfg_we_i,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic              cfg_mode_i,
   input  logic [CNT_W-1:0]  cfg_len_i,
   output logic [NUM_CH-1:0] filt_data_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   input  logic [NUM_CH-1:0] irq_clr_i,
   output logic [NUM_CH-1:0] irq_status_o,
   output logic              irq_o
);

   typedef enum logic [1:0] {
      ST_STABLE,
      ST_COUNT,
      ST_BLANK
   } state_t;

   localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

   // Channel indices that the select field can encode but that do not exist are dropped here.
   logic cfg_valid;
   assign cfg_valid = cfg_we_i && ({1'b0, cfg_ch_i} < NUM_CH_X);

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(n);

      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] len;
      logic             filt;
      logic             rise;
      logic             fall;
      logic             wd_rst;
      logic             blank_second;
      logic             cfg_hit;
      logic             din;

      assign cfg_hit = cfg_valid && (cfg_ch_i == CH_IDX);
      assign din     = sync_data_i[n];

      // A config write pre-empts the filter, so an update that would land in the same cycle is dropped.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state        <= ST_STABLE;
            cnt          <= '0;
            len          <= DEF_LEN;
            filt         <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            wd_rst       <= 1'b1;
            blank_second <= 1'b0;
         end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (cfg_hit) begin
               len          <= cfg_len_i;
               wd_rst       <= cfg_mode_i;
               cnt          <= '0;
               blank_second <= 1'b0;
               state        <= (cfg_mode_i != wd_rst) ? ST_BLANK : ST_STABLE;
            end else begin
               case (state)
                  ST_STABLE: begin
                     cnt <= '0;
                     if (din != filt) begin
                        if (len == '0) begin
                           filt <= din;
                           rise <= din;
                           fall <= ~din;
                        end else begin
                           cnt   <= CNT_W'(1);
                           state <= ST_COUNT;
                        end
                     end
                  end
                  ST_COUNT: begin
                     if (din == filt) begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                     end else if (cnt == len) begin
                        filt  <= din;
                        rise  <= din;
                        fall  <= ~din;
                        cnt   <= '0;
                        state <= ST_STABLE;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  ST_BLANK: begin
                     cnt <= '0;
                     if (blank_second) begin
                        blank_second <= 1'b0;
                        state        <= ST_STABLE;
                     end else begin
                        blank_second <= 1'b1;
                     end
                  end
                  default: begin
                     cnt   <= '0;
                     state <= ST_STABLE;
                  end
               endcase
            end
         end
      end

      assign filt_data_o[n] = filt;
      assign rise_o[n]      = rise;
      assign fall_o[n]      = fall;
      assign wd_rst_o[n]    = wd_rst;
   end

`ifdef FILTER_IRQ_EN
   logic [NUM_CH-1:0] irq_status;
   logic              irq_q;

   // Status captures the registered event pulses; a set beats a clear arriving in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_status <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_status <= (irq_status & ~irq_clr_i) | rise_o | fall_o;
         irq_q      <= |irq_status;
      end
   end

   assign irq_status_o = irq_status;
   assign irq_o        = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = ^irq_clr_i;
   assign irq_status_o   = '0;
   assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_input_filter_ctrl.sv
// Directed self-checking bench for input_filter_ctrl; a second 3-channel instance covers out-of-range writes.
module tb_input_filter_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [3:0] sync_data_i;
   logic [3:0] wd_rst_o;
   logic       cfg_we_i;
   logic [1:0] cfg_ch_i;
   logic       cfg_mode_i;
   logic [7:0] cfg_len_i;
   logic [3:0] filt_data_o;
   logic [3:0] rise_o;
   logic [3:0] fall_o;
   logic [3:0] irq_clr_i;
   logic [3:0] irq_status_o;
   logic       irq_o;

   logic [2:0] sync3;
   logic [2:0] wd_rst3;
   logic       cfg_we3;
   logic [1:0] cfg_ch3;
   logic       cfg_mode3;
   logic [7:0] cfg_len3;
   logic [2:0] filt3;
   logic [2:0] rise3;
   logic [2:0] fall3;
   logic [2:0] irq_status3;
   logic       irq3;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   input_filter_ctrl #(.NUM_CH(4), .CNT_W(8), .DEF_LEN(8'd3)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .sync_data_i(sync_data_i), .wd_rst_o(wd_rst_o),
      .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_mode_i(cfg_mode_i), .cfg_len_i(cfg_len_i),
      .filt_data_o(filt_data_o), .rise_o(rise_o), .fall_o(fall_o),
      .irq_clr_i(irq_clr_i), .irq_status_o(irq_status_o), .irq_o(irq_o)
   );

   input_filter_ctrl #(.NUM_CH(3), .CNT_W(8), .DEF_LEN(8'd3)) u_dut3 (
      .clk_i(clk_i), .rst_i(rst_i), .sync_data_i(sync3), .wd_rst_o(wd_rst3),
      .cfg_we_i(cfg_we3), .cfg_ch_i(cfg_ch3), .cfg_mode_i(cfg_mode3), .cfg_len_i(cfg_len3),
      .filt_data_o(filt3), .rise_o(rise3), .fall_o(fall3),
      .irq_clr_i(3'b000), .irq_status_o(irq_status3), .irq_o(irq3)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      sync_data_i = '0; cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_mode_i = 1'b1; cfg_len_i = '0; irq_clr_i = '0;
      sync3 = '0; cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_mode3 = 1'b1; cfg_len3 = '0;
      tick(); tick();
      rst_i = 1'b0;
      checks++;
      if ({filt_data_o, rise_o, fall_o} !== 12'h000) begin
         errors++; $display("[TB] FAIL reset_outputs filt/rise/fall got %h want 000", {filt_data_o, rise_o, fall_o});
      end
      checks++;
      if (wd_rst_o !== 4'b1111) begin
         errors++; $display("[TB] FAIL reset_wd_rst got %b want 1111", wd_rst_o);
      end
      checks++;
      if ({irq_status_o, irq_o} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_irq got %b want 00000", {irq_status_o, irq_o});
      end
   endtask

   task automatic test_default_filter();
      sync_data_i[0] = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         checks++;
         if (filt_data_o[0] !== (e >= 4)) begin
            errors++; $display("[TB] FAIL default_filt edge %0d got %b want %b", e, filt_data_o[0], (e >= 4));
         end
         checks++;
         if (rise_o[0] !== (e == 4)) begin
            errors++; $display("[TB] FAIL default_rise edge %0d got %b want %b", e, rise_o[0], (e == 4));
         end
      end
      checks++;
      if (wd_rst_o !== 4'b1111) begin
         errors++; $display("[TB] FAIL default_wd_rst got %b want 1111", wd_rst_o);
      end
   endtask

   task automatic test_glitch();
      sync_data_i[1] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         if (e == 4) sync_data_i[1] = 1'b0;
         tick();
         checks++;
         if ({filt_data_o[1], rise_o[1], fall_o[1]} !== 3'b000) begin
            errors++; $display("[TB] FAIL glitch edge %0d filt/rise/fall got %b want 000", e, {filt_data_o[1], rise_o[1], fall_o[1]});
         end
      end
      // A fresh full-length pulse must still need exactly L+1 edges, proving the count restarted.
      sync_data_i[1] = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if ({filt_data_o[1], rise_o[1]} !== {2{e == 4}}) begin
            errors++; $display("[TB] FAIL glitch_recover edge %0d filt/rise got %b want %b", e, {filt_data_o[1], rise_o[1]}, {2{e == 4}});
         end
      end
      sync_data_i[1] = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if ({filt_data_o[1], fall_o[1]} !== {e != 4, e == 4}) begin
            errors++; $display("[TB] FAIL glitch_fall edge %0d filt/fall got %b want %b", e, {filt_data_o[1], fall_o[1]}, {e != 4, e == 4});
         end
      end
   endtask

   task automatic test_bypass();
      logic [3:0] pat;
      pat = 4'b0101;
      cfg_we_i = 1'b1; cfg_ch_i = 2'd2; cfg_mode_i = 1'b1; cfg_len_i = 8'd0;
      tick();
      cfg_we_i = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         sync_data_i[2] = ~pat[i];
         tick();
         checks++;
         if ({filt_data_o[2], rise_o[2], fall_o[2]} !== {~pat[i], ~pat[i], pat[i]}) begin
            errors++; $display("[TB] FAIL bypass step %0d filt/rise/fall got %b want %b", 3 - i,
                               {filt_data_o[2], rise_o[2], fall_o[2]}, {~pat[i], ~pat[i], pat[i]});
         end
      end
      checks++;
      if ({wd_rst_o, filt_data_o[0]} !== 5'b11111) begin
         errors++; $display("[TB] FAIL bypass_others wd_rst/filt0 got %b want 11111", {wd_rst_o, filt_data_o[0]});
      end
   endtask

   task automatic test_mode_change();
      sync_data_i[3] = 1'b1;
      cfg_we_i = 1'b1; cfg_ch_i = 2'd3; cfg_mode_i = 1'b0; cfg_len_i = 8'd3;
      tick();
      cfg_we_i = 1'b0;
      checks++;
      if ({wd_rst_o, filt_data_o[3], rise_o[3]} !== 6'b011100) begin
         errors++; $display("[TB] FAIL mode_wd_rst wd/filt3/rise3 got %b want 011100", {wd_rst_o, filt_data_o[3], rise_o[3]});
      end
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++;
         if ({filt_data_o[3], rise_o[3]} !== {e >= 6, e == 6}) begin
            errors++; $display("[TB] FAIL mode_filter edge %0d filt/rise got %b want %b", e, {filt_data_o[3], rise_o[3]}, {e >= 6, e == 6});
         end
      end
   endtask

   task automatic test_collision();
      sync_data_i[0] = 1'b0;
      tick(); tick(); tick();
      cfg_we_i = 1'b1; cfg_ch_i = 2'd0; cfg_mode_i = 1'b1; cfg_len_i = 8'd3;
      tick();
      cfg_we_i = 1'b0;
      checks++;
      if ({filt_data_o[0], fall_o[0], wd_rst_o[0]} !== 3'b101) begin
         errors++; $display("[TB] FAIL collision filt/fall/wd got %b want 101", {filt_data_o[0], fall_o[0], wd_rst_o[0]});
      end
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if ({filt_data_o[0], fall_o[0]} !== {e != 4, e == 4}) begin
            errors++; $display("[TB] FAIL collision_restart edge %0d filt/fall got %b want %b", e, {filt_data_o[0], fall_o[0]}, {e != 4, e == 4});
         end
      end
      // Channel 3 does not exist on the 3-channel instance, so this write must leave it untouched.
      cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_mode3 = 1'b0; cfg_len3 = 8'd0;
      tick();
      cfg_we3 = 1'b0;
      sync3 = 3'b111;
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if ({wd_rst3, filt3} !== {3'b111, {3{e == 4}}}) begin
            errors++; $display("[TB] FAIL out_of_range edge %0d wd/filt got %b want %b", e, {wd_rst3, filt3}, {3'b111, {3{e == 4}}});
         end
      end
   endtask

   task automatic test_irq();
      logic [1:0] want [1:4];
      irq_clr_i = 4'hF;
      tick();
      irq_clr_i = 4'h0;
      tick();
      sync_data_i[1] = 1'b1;
      tick(); tick(); tick(); tick();
      checks++;
      if (rise_o[1] !== 1'b1) begin
         errors++; $display("[TB] FAIL irq_rise got %b want 1", rise_o[1]);
      end
`ifdef FILTER_IRQ_EN
      want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b01; want[4] = 2'b00;
`else
      want[1] = 2'b00; want[2] = 2'b00; want[3] = 2'b00; want[4] = 2'b00;
`endif
      for (int s = 1; s <= 4; s++) begin
         irq_clr_i[1] = (s == 1 || s == 3);
         tick();
         checks++;
         if ({irq_status_o[1], irq_o} !== want[s]) begin
            errors++; $display("[TB] FAIL irq step %0d status1/irq got %b want %b", s, {irq_status_o[1], irq_o}, want[s]);
         end
      end
      irq_clr_i = 4'h0;
   endtask

   initial begin
      $display("[TB] starting input_filter_ctrl bench");
      test_reset();
      test_default_filter();
      test_glitch();
      test_bypass();
      test_mode_change();
      test_collision();
      test_irq();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
